// File: rtl/jtag_pkg.sv
// Shared constants for the JTAG instruction/data register stage.
package jtag_pkg;

    localparam int unsigned IR_WIDTH_DEFAULT = 5;

    localparam logic [IR_WIDTH_DEFAULT-1:0] INSTR_IDCODE = 5'h01;
    localparam logic [IR_WIDTH_DEFAULT-1:0] INSTR_BYPASS = 5'h1F;
    localparam logic [IR_WIDTH_DEFAULT-1:0] INSTR_USER   = 5'h10;

    // Capture-IR loads 2'b01 into the LSBs, zeros above.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h1002_AC05;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift register clocked on the rising edge of tck, LSB shifts out first.
module jtag_shift_reg
    import jtag_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter logic [WIDTH-1:0] CAPTURE_VAL = '0
) (
    input  logic             tck,
    input  logic             reset,
    input  logic             clear,
    input  logic             capture,
    input  logic             shift,
    input  logic             tdi,
    output logic [WIDTH-1:0] q,
    output logic             lsb
);

    // Synchronous clear beats capture, capture beats shift; tdi enters at the MSB.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (capture) begin
            q <= CAPTURE_VAL;
        end else if (shift) begin
            q <= {tdi, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/jtag_ir_dr.sv
// JTAG instruction register, BYPASS/IDCODE data registers, user DR strobe gating
// and the falling-edge retimed TDO.
module jtag_ir_dr
    import jtag_pkg::*;
#(
    parameter int unsigned        IR_WIDTH   = IR_WIDTH_DEFAULT,
    parameter logic [31:0]        IDCODE_VAL = IDCODE_DEFAULT,
    parameter logic [IR_WIDTH-1:0] USER_INSTR = IR_WIDTH'(INSTR_USER)
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tl_reset_n,
    input  logic                tdi,
    input  logic                shiftIR,
    input  logic                captureIR,
    input  logic                updateIR,
    input  logic                shiftDR,
    input  logic                captureDR,
    input  logic                updateDR,
    input  logic                select,
    input  logic                tdo_en,
    input  logic                user_tdo,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [IR_WIDTH-1:0] instr,
    output logic                sel_bypass,
    output logic                sel_idcode,
    output logic                sel_user,
    output logic                user_capture,
    output logic                user_shift,
    output logic                user_update
);

    localparam logic [IR_WIDTH-1:0] opIdcode = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] opBypass = IR_WIDTH'(INSTR_BYPASS);
    localparam logic [IR_WIDTH-1:0] irCapVal = IR_WIDTH'(IR_CAPTURE_LSBS);

    logic [IR_WIDTH-1:0] irSr;
    logic                irLsb;
    logic                irClear;
    logic                irCapture;
    logic                irShift;
    logic [31:0]         idcodeSr;
    logic                idcodeLsb;
    logic                idcodeCapture;
    logic                idcodeShift;
    logic                bypassReg;
    logic                drTdo;
    logic                isBypassOp;
    logic                unusedIdcodeUpper;

    // Test-Logic-Reset clears the IR; updateIR outranks capture/shift so the
    // register holds while its value is transferred to instr.
    assign irClear   = ~tl_reset_n;
    assign irCapture = captureIR & ~updateIR;
    assign irShift   = shiftIR & ~updateIR;

    jtag_shift_reg #(
        .WIDTH       (IR_WIDTH),
        .CAPTURE_VAL (irCapVal)
    ) irReg (
        .tck     (tck),
        .reset   (reset),
        .clear   (irClear),
        .capture (irCapture),
        .shift   (irShift),
        .tdi     (tdi),
        .q       (irSr),
        .lsb     (irLsb)
    );

    assign idcodeCapture = captureDR & sel_idcode;
    assign idcodeShift   = shiftDR & sel_idcode;

    jtag_shift_reg #(
        .WIDTH       (32),
        .CAPTURE_VAL (IDCODE_VAL)
    ) idcodeReg (
        .tck     (tck),
        .reset   (reset),
        .clear   (1'b0),
        .capture (idcodeCapture),
        .shift   (idcodeShift),
        .tdi     (tdi),
        .q       (idcodeSr),
        .lsb     (idcodeLsb)
    );

    // Upper IDCODE bits only ever leave serially through the LSB.
    assign unusedIdcodeUpper = ^idcodeSr[31:1];

    // Current instruction: IDCODE out of reset/Test-Logic-Reset, else loaded on Update-IR.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            instr <= opIdcode;
        end else if (!tl_reset_n) begin
            instr <= opIdcode;
        end else if (updateIR) begin
            instr <= irSr;
        end
    end

    // One-hot decode; every opcode other than IDCODE and USER falls back to BYPASS.
    assign isBypassOp = (instr == opBypass);
    assign sel_idcode = (instr == opIdcode);
    assign sel_user   = (instr == USER_INSTR) & ~sel_idcode;
    assign sel_bypass = isBypassOp | (~sel_idcode & ~sel_user);

    assign user_capture = captureDR & sel_user;
    assign user_shift   = shiftDR & sel_user;
    assign user_update  = updateDR & sel_user;

    // One-bit BYPASS register: captures 0, then passes tdi through with one cycle delay.
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            bypassReg <= 1'b0;
        end else if (captureDR && sel_bypass) begin
            bypassReg <= 1'b0;
        end else if (shiftDR && sel_bypass) begin
            bypassReg <= tdi;
        end
    end

    // Serial output of whichever data register the instruction selects.
    always_comb begin
        drTdo = bypassReg;
        if (sel_idcode) begin
            drTdo = idcodeLsb;
        end else if (sel_user) begin
            drTdo = user_tdo;
        end
    end

    // TDO is retimed on the falling edge so it is stable around the next rising edge.
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            tdo <= 1'b0;
        end else begin
            tdo <= select ? irLsb : drTdo;
        end
    end

    assign tdo_oe = tdo_en;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Self-checking bench for jtag_ir_dr: directed test-plan sequences, a decode
// vector table and a randomized run against a queue-based reference model.
module tb_jtag_ir_dr;

    localparam logic [31:0] IDC   = 32'h1002_AC05;
    localparam logic [4:0]  USERC = 5'h10;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_SIR  = 6'b100000;
    localparam logic [5:0] S_CIR  = 6'b010000;
    localparam logic [5:0] S_UIR  = 6'b001000;
    localparam logic [5:0] S_SDR  = 6'b000100;
    localparam logic [5:0] S_CDR  = 6'b000010;
    localparam logic [5:0] S_UDR  = 6'b000001;

    logic       tck = 1'b0;
    logic       reset, tl_reset_n, tdi;
    logic       shiftIR, captureIR, updateIR, shiftDR, captureDR, updateDR;
    logic       select, tdo_en, user_tdo;
    logic       tdo, tdo_oe;
    logic [4:0] instr;
    logic       sel_bypass, sel_idcode, sel_user;
    logic       user_capture, user_shift, user_update;

    int vectors = 0;
    int miscompares = 0;

    jtag_ir_dr #(
        .IR_WIDTH   (5),
        .IDCODE_VAL (IDC),
        .USER_INSTR (USERC)
    ) dut (
        .tck          (tck),
        .reset        (reset),
        .tl_reset_n   (tl_reset_n),
        .tdi          (tdi),
        .shiftIR      (shiftIR),
        .captureIR    (captureIR),
        .updateIR     (updateIR),
        .shiftDR      (shiftDR),
        .captureDR    (captureDR),
        .updateDR     (updateDR),
        .select       (select),
        .tdo_en       (tdo_en),
        .user_tdo     (user_tdo),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .instr        (instr),
        .sel_bypass   (sel_bypass),
        .sel_idcode   (sel_idcode),
        .sel_user     (sel_user),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update)
    );

    always #5 tck = ~tck;

    // Reference model: registers as bit queues, LSB (next bit out) at the front.
    bit         irQ[$];
    bit         idQ[$];
    logic [4:0] mInstr;
    logic       mBy;
    logic       mTdo;

    function automatic int kindOf(input logic [4:0] op);
        if (op == 5'h01) return 1;
        if (op == USERC) return 2;
        return 0;
    endfunction

    function automatic logic [2:0] selOf(input int k);
        if (k == 1) return 3'b010;
        if (k == 2) return 3'b001;
        return 3'b100;
    endfunction

    function automatic logic [4:0] irWord();
        logic [4:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v[i] = irQ[i];
        return v;
    endfunction

    task automatic modelReset();
        irQ = '{0, 0, 0, 0, 0};
        idQ.delete();
        for (int i = 0; i < 32; i++) idQ.push_back(1'b0);
        mInstr = 5'h01;
        mBy = 1'b0;
        mTdo = 1'b0;
    endtask

    task automatic modelRise();
        int k;
        logic [31:0] cap;
        k = kindOf(mInstr);
        cap = IDC;
        if (captureDR) begin
            if (k == 0) mBy = 1'b0;
            else if (k == 1) begin
                idQ.delete();
                for (int i = 0; i < 32; i++) idQ.push_back(cap[i]);
            end
        end else if (shiftDR) begin
            if (k == 0) mBy = tdi;
            else if (k == 1) begin
                idQ.push_back(tdi);
                void'(idQ.pop_front());
            end
        end
        if (!tl_reset_n) begin
            irQ = '{0, 0, 0, 0, 0};
            mInstr = 5'h01;
        end else if (updateIR) begin
            mInstr = irWord();
        end else if (captureIR) begin
            irQ = '{1, 0, 0, 0, 0};
        end else if (shiftIR) begin
            irQ.push_back(tdi);
            void'(irQ.pop_front());
        end
    endtask

    task automatic modelFall();
        int k;
        k = kindOf(mInstr);
        if (select) mTdo = irQ[0];
        else if (k == 1) mTdo = idQ[0];
        else if (k == 2) mTdo = user_tdo;
        else mTdo = mBy;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] st, input logic d, input logic s);
        {shiftIR, captureIR, updateIR, shiftDR, captureDR, updateDR} = st;
        tdi = d;
        select = s;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic clockOut();
        @(posedge tck);
        modelRise();
        #1;
        @(negedge tck);
        modelFall();
        #1;
    endtask

    task automatic cyc(input logic [5:0] st, input logic d, input logic s);
        drive(st, d, s);
        clockOut();
    endtask

    task automatic loadIr(input logic [4:0] op);
        cyc(S_CIR, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(S_SIR, op[i], 1'b1);
        cyc(S_NONE, 1'b0, 1'b1);
        cyc(S_UIR, 1'b0, 1'b1);
        cyc(S_NONE, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [4:0] op;
        logic [2:0] expSel;  // {bypass, idcode, user}
    } decodeVec_t;

    decodeVec_t decTab[8];

    initial begin
        logic [31:0] got;
        logic [5:0]  st;
        int          r;

        decTab[0] = '{5'h1F, 3'b100};
        decTab[1] = '{5'h01, 3'b010};
        decTab[2] = '{5'h0B, 3'b100};
        decTab[3] = '{5'h10, 3'b001};
        decTab[4] = '{5'h00, 3'b100};
        decTab[5] = '{5'h02, 3'b100};
        decTab[6] = '{5'h1E, 3'b100};
        decTab[7] = '{5'h11, 3'b100};

        drive(S_NONE, 1'b0, 1'b0);
        tl_reset_n = 1'b1;
        tdo_en = 1'b1;
        user_tdo = 1'b0;
        reset = 1'b1;
        modelReset();
        #2;
        chk("reset_instr", instr, 5'h01);
        chk("reset_sel", {sel_bypass, sel_idcode, sel_user}, 3'b010);
        chk("reset_tdo", tdo, 1'b0);
        chk("reset_oe", tdo_oe, 1'b1);
        chk("reset_user", {user_capture, user_shift, user_update}, 3'b000);
        #1 reset = 1'b0;
        @(negedge tck);
        #1;

        // IDCODE read-out straight after reset.
        cyc(S_NONE, 1'b0, 1'b0);
        cyc(S_NONE, 1'b0, 1'b0);
        cyc(S_CDR, 1'b0, 1'b0);
        got = '0;
        got[0] = tdo;
        for (int i = 1; i < 32; i++) begin
            cyc(S_SDR, 1'b0, 1'b0);
            got[i] = tdo;
        end
        cyc(S_SDR, 1'b0, 1'b0);
        cyc(S_NONE, 1'b0, 1'b0);
        chk("idcode_read", got, IDC);
        chk("idcode_sel", sel_idcode, 1'b1);

        // Decode table.
        for (int i = 0; i < 8; i++) begin
            loadIr(decTab[i].op);
            chk("dec_instr", instr, decTab[i].op);
            chk("dec_sel", {sel_bypass, sel_idcode, sel_user}, decTab[i].expSel);
        end

        // BYPASS: TDI 1,0,1,1 returns 0,1,0,1.
        loadIr(5'h1F);
        got = '0;
        cyc(S_CDR, 1'b0, 1'b0); got[0] = tdo;
        cyc(S_SDR, 1'b1, 1'b0); got[1] = tdo;
        cyc(S_SDR, 1'b0, 1'b0); got[2] = tdo;
        cyc(S_SDR, 1'b1, 1'b0); got[3] = tdo;
        cyc(S_SDR, 1'b1, 1'b0);
        cyc(S_NONE, 1'b0, 1'b0);
        chk("bypass_stream", got, 32'b1010);

        // Capture-IR pattern, then an undefined opcode.
        got = '0;
        cyc(S_CIR, 1'b0, 1'b1); got[0] = tdo;
        for (int i = 1; i < 5; i++) begin
            cyc(S_SIR, 1'b0, 1'b1);
            got[i] = tdo;
        end
        cyc(S_NONE, 1'b0, 1'b1);
        chk("ir_capture", got, 32'b00001);
        loadIr(5'h0B);
        chk("undef_bypass", sel_bypass, 1'b1);

        // User DR strobe gating and TDO pass-through.
        loadIr(USERC);
        drive(S_CDR, 1'b0, 1'b0); #1;
        chk("user_cap", {user_capture, user_shift, user_update}, 3'b100);
        clockOut();
        for (int i = 0; i < 3; i++) begin
            user_tdo = (i != 1);
            drive(S_SDR, 1'b0, 1'b0); #1;
            chk("user_shift", {user_capture, user_shift, user_update}, 3'b010);
            clockOut();
            chk("user_tdo", tdo, (i != 1));
        end
        drive(S_NONE, 1'b0, 1'b0); #1;
        chk("user_idle", {user_capture, user_shift, user_update}, 3'b000);
        clockOut();
        drive(S_UDR, 1'b0, 1'b0); #1;
        chk("user_upd", {user_capture, user_shift, user_update}, 3'b001);
        clockOut();
        drive(S_NONE, 1'b0, 1'b0); #1;
        chk("user_after", {user_capture, user_shift, user_update}, 3'b000);
        clockOut();

        // Test-Logic-Reset returns to IDCODE on the next rising edge.
        loadIr(5'h1F);
        tl_reset_n = 1'b0;
        drive(S_NONE, 1'b0, 1'b0); #1;
        chk("tlr_before", instr, 5'h1F);
        clockOut();
        chk("tlr_instr", instr, 5'h01);
        chk("tlr_sel", sel_idcode, 1'b1);
        for (int i = 0; i < 4; i++) cyc(S_NONE, 1'b0, 1'b0);
        tl_reset_n = 1'b1;
        cyc(S_NONE, 1'b0, 1'b0);

        // Asynchronous reset in the middle of an IR shift.
        loadIr(5'h1F);
        for (int i = 0; i < 3; i++) cyc(S_SIR, 1'b0, 1'b1);
        chk("midshift_tdo", tdo, 1'b1);
        reset = 1'b1;
        modelReset();
        #1;
        chk("areset_tdo", tdo, 1'b0);
        chk("areset_instr", instr, 5'h01);
        #1 reset = 1'b0;
        drive(S_NONE, 1'b0, 1'b1);
        clockOut();
        chk("rel_instr", instr, 5'h01);
        chk("rel_irlsb", tdo, 1'b0);
        cyc(S_UIR, 1'b0, 1'b1);
        chk("rel_irzero", instr, 5'h00);
        chk("rel_bypass", sel_bypass, 1'b1);
        cyc(S_NONE, 1'b0, 1'b0);

        // Randomized run against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: st = S_SIR;
                1: st = S_CIR;
                2: st = S_UIR;
                3: st = S_SDR;
                4: st = S_CDR;
                5: st = S_UDR;
                default: st = S_NONE;
            endcase
            tl_reset_n = ($urandom_range(0, 24) != 0);
            tdo_en = $urandom_range(0, 1);
            user_tdo = $urandom_range(0, 1);
            drive(st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            chk("rnd_instr", instr, mInstr);
            chk("rnd_sel", {sel_bypass, sel_idcode, sel_user}, selOf(kindOf(mInstr)));
            chk("rnd_user", {user_capture, user_shift, user_update},
                (kindOf(mInstr) == 2) ? {captureDR, shiftDR, updateDR} : 3'b000);
            chk("rnd_oe", tdo_oe, tdo_en);
            clockOut();
            chk("rnd_tdo", tdo, mTdo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
